// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity selectors and baud divisor helper
// Contents:
//   rx_state_t      receiver FSM state encoding
//   CHECK_ODD/EVEN  values for the CHECK_SEL parity-mode parameter
//   CNT_W           width of the baud counter
//   baud_div()      clocks per bit for a clock in MHz and a baud rate
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int CHECK_ODD  = 1;
  localparam int CHECK_EVEN = 0;

  localparam int CNT_W = 15;

  function automatic int baud_div(input int clk_mhz, input int bps);
    return (clk_mhz * 1000000) / bps;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer, history flop and falling-edge detect
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   rx_i    asynchronous serial line (idles high)
//   rx_s    synchronized line level
//   fall    high for one cycle when the synchronized line goes 1 -> 0
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s,
  output logic fall
);

  logic s1, s2, s3;

  // All three flops reset to the idle level so that releasing reset while
  // the line sits high can never look like a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rx_s = s2;
  // Requires s3 == 1: after a break the line must be seen high again first.
  assign fall = s3 & ~s2;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start, 8 data bits LSB first, parity, one stop bit
// Parameters:
//   CLK_FREQ   system clock in MHz
//   UART_BPS   baud rate
//   CHECK_SEL  parity mode, CHECK_ODD or CHECK_EVEN
// Ports:
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   u_rx_i           asynchronous serial input, idles high
//   rx_data_o        last received byte, held until the next strobe
//   rx_valid_o       one-cycle strobe per completed frame
//   rx_parity_err_o  parity mismatch for rx_data_o
//   rx_frame_err_o   stop bit sampled low for rx_data_o
//   rx_busy_o        receiver is inside a frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50,
  parameter int UART_BPS  = 9600,
  parameter int CHECK_SEL = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       u_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_parity_err_o,
  output logic       rx_frame_err_o,
  output logic       rx_busy_o
);

  localparam int BPS_DR = baud_div(CLK_FREQ, UART_BPS);
  localparam int HALF   = BPS_DR / 2;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BPS_DR - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             par_q;

  logic rx_s, fall;
  logic half_tick, bit_tick;
  logic cnt_clr, shift_en, par_en, frame_done;
  logic parity_x;

  uart_rx_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx_i  (u_rx_i),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign half_tick = (cnt_q == HALF_LAST);
  assign bit_tick  = (cnt_q == BIT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_clr = 1'b1;
        if (fall) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        // Mid-start check: a line already back high was only a glitch.
        if (half_tick) begin
          cnt_clr = 1'b1;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (bit_tick) begin
          cnt_clr = 1'b1;
          par_en  = 1'b1;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leaving at mid-stop gives half a bit of slack for a back-to-back start.
        if (bit_tick) begin
          cnt_clr    = 1'b1;
          frame_done = 1'b1;
          state_d    = RX_IDLE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = RX_IDLE;
      end
    endcase
  end

  // The start half-period re-bases the counter so later ticks land mid-bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
    end else begin
      if (state_q != RX_DATA) begin
        bit_idx_q <= 3'd0;
      end else if (shift_en) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[7:1]};
      end
      if (par_en) begin
        par_q <= rx_s;
      end
    end
  end

  assign parity_x = ^{shift_q, par_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o       <= 8'h00;
      rx_valid_o      <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
    end else begin
      rx_valid_o <= frame_done;
      if (frame_done) begin
        rx_data_o       <= shift_q;
        rx_parity_err_o <= (CHECK_SEL == CHECK_ODD) ? ~parity_x : parity_x;
        rx_frame_err_o  <= ~rx_s;
      end
    end
  end

  assign rx_busy_o = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with odd and even parity instances
module tb_uart_rx;

  localparam int BPS = 10;
  localparam int LAT = 107;

  logic clk_i  = 1'b0;
  logic rst_i  = 1'b1;
  logic u_rx   = 1'b1;

  logic [7:0] data_o, data_e;
  logic       v_o, v_e, pe_o, pe_e, fe_o, fe_e, b_o, b_e;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr_odd;
    logic       perr_even;
    logic       ferr;
    int         edge_at;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) edge_n <= edge_n + 1;

  uart_rx #(.CLK_FREQ(1), .UART_BPS(100000), .CHECK_SEL(1)) u_odd (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .u_rx_i          (u_rx),
    .rx_data_o       (data_o),
    .rx_valid_o      (v_o),
    .rx_parity_err_o (pe_o),
    .rx_frame_err_o  (fe_o),
    .rx_busy_o       (b_o)
  );

  uart_rx #(.CLK_FREQ(1), .UART_BPS(100000), .CHECK_SEL(0)) u_even (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .u_rx_i          (u_rx),
    .rx_data_o       (data_e),
    .rx_valid_o      (v_e),
    .rx_parity_err_o (pe_e),
    .rx_frame_err_o  (fe_e),
    .rx_busy_o       (b_e)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding frame, in content and timing.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (v_o || v_e) begin
      check_eq("valid_pair", 32'(v_e), 32'(v_o));
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("strobe_edge", edge_n, e.edge_at);
        check_eq("odd_data",  32'(data_o), 32'(e.data));
        check_eq("odd_perr",  32'(pe_o),   32'(e.perr_odd));
        check_eq("odd_ferr",  32'(fe_o),   32'(e.ferr));
        check_eq("even_data", 32'(data_e), 32'(e.data));
        check_eq("even_perr", 32'(pe_e),   32'(e.perr_even));
        check_eq("even_ferr", 32'(fe_e),   32'(e.ferr));
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Called at posedge+1; the next edge is the one where s1 first sees the start bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int tail_low, input int gap);
    exp_t       e;
    logic [10:0] bits;
    int         ones;
    bits        = {stop, par, d, 1'b0};
    ones        = $countones({d, par});
    e.data      = d;
    e.perr_odd  = (ones % 2) == 0;
    e.perr_even = (ones % 2) == 1;
    e.ferr      = ~stop;
    e.edge_at   = edge_n + 1 + LAT;
    exp_q.push_back(e);
    for (int i = 0; i < 11; i++) begin
      u_rx = bits[i];
      idle_cycles(BPS);
    end
    if (tail_low > 0) begin
      u_rx = 1'b0;
      idle_cycles(tail_low);
    end
    u_rx = 1'b1;
    if (gap > 0) idle_cycles(gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data_odd"},  32'(data_o), 32'h0);
    check_eq({tag, "_valid_odd"}, 32'(v_o),    32'h0);
    check_eq({tag, "_perr_odd"},  32'(pe_o),   32'h0);
    check_eq({tag, "_ferr_odd"},  32'(fe_o),   32'h0);
    check_eq({tag, "_busy_odd"},  32'(b_o),    32'h0);
    check_eq({tag, "_data_even"}, 32'(data_e), 32'h0);
    check_eq({tag, "_busy_even"}, 32'(b_e),    32'h0);
  endtask

  initial begin : stim
    logic [7:0]  d;
    logic [7:0]  last_data;
    logic [10:0] bits;
    logic        par, stop;
    int          gap, e0, rel;

    rst_i = 1'b1;
    u_rx  = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle_cycles(5);

    // Good frame, parity error, framing error followed by a 50-cycle break.
    send_frame(8'h55, 1'b1, 1'b1, 0, 20);
    send_frame(8'h55, 1'b0, 1'b1, 0, 20);
    send_frame(8'hA3, 1'b1, 1'b0, 50, 20);

    // Three-cycle low glitch: busy only over the start half-bit, no strobe.
    u_rx = 1'b0;
    e0   = edge_n + 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      rel = edge_n - e0;
      if (rel == 2) u_rx = 1'b1;
      check_eq("glitch_busy_odd",  32'(b_o), 32'((rel >= 2) && (rel <= 6)));
      check_eq("glitch_busy_even", 32'(b_e), 32'((rel >= 2) && (rel <= 6)));
    end
    @(posedge clk_i);
    #1;
    idle_cycles(20);

    // Back-to-back with no idle gap between frames.
    send_frame(8'h00, 1'b1, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b1, 1'b1, 0, 20);

    // Reset asserted during data bit 4; the partial frame must vanish.
    d    = 8'h3C;
    bits = {1'b1, 1'b1, d, 1'b0};
    for (int i = 0; i < 5; i++) begin
      u_rx = bits[i];
      idle_cycles(BPS);
    end
    u_rx = bits[5];
    idle_cycles(5);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("midreset");
    u_rx  = 1'b1;
    rst_i = 1'b0;
    idle_cycles(150);

    send_frame(8'hC6, 1'b1, 1'b1, 0, 20);
    last_data = 8'hC6;

    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom_range(0, 255));
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 4) != 0);
      gap  = $urandom_range(0, 12);
      if (!stop && gap < 3) gap = 3;
      send_frame(d, par, stop, 0, gap);
      last_data = d;
    end

    idle_cycles(200);
    check_eq("pending_frames", 32'(exp_q.size()), 32'd0);
    check_eq("held_data_odd",  32'(data_o), 32'(last_data));
    check_eq("held_data_even", 32'(data_e), 32'(last_data));
    check_eq("idle_busy",      32'(b_o | b_e), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
